// File: rtl/signed_rshift_mul_ctrl_if.sv
// Operand/product handshake bundle for signed_rshift_mul_ctrl.
// master: the side that supplies operands and takes products.
// slave: the sequencer.
interface signed_rshift_mul_ctrl_if #(
    parameter int unsigned k = 3
) ();
    logic           in_valid;
    logic           in_ready;
    logic [k-1:0]   a_in;
    logic [k-1:0]   b_in;
    logic [2*k-1:0] prod;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, prod, out_valid
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, prod, out_valid
    );
endinterface

// File: rtl/signed_rshift_mul_ctrl.sv
// Sequencer for a k-bit right-shift signed multiplier datapath.
// Accepts an operand pair, runs k add/shift iterations (the last one
// subtracts), captures the product in the single cycle it is valid and
// holds it until the consumer takes it.
module signed_rshift_mul_ctrl #(
    parameter int unsigned k = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    signed_rshift_mul_ctrl_if.slave bus,
    output logic [k-1:0]            m_cand,
    output logic [k-1:0]            m_ier,
    output logic                    start,
    output logic                    sel,
    output logic                    done,
    input  logic [2*k:0]            mul_result,
    output logic                    busy
);

    localparam int unsigned CntW = $clog2(k) + 1;
    localparam logic [CntW-1:0] LastIter = CntW'(k - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StCapt,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [k-1:0]    m_cand_q, m_cand_d;
    logic [k-1:0]    m_ier_q, m_ier_d;
    logic [2*k-1:0]  prod_q, prod_d;

    // Bit 2k is a redundant copy of the product sign.
    logic unused_sign;
    assign unused_sign = mul_result[2*k];

    // State, counter, operand and product registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            m_cand_q <= '0;
            m_ier_q  <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_cand_q <= m_cand_d;
            m_ier_q  <= m_ier_d;
            prod_q   <= prod_d;
        end
    end

    // Next-state and strobe decode; strobes depend on state and cnt only.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        m_cand_d      = m_cand_q;
        m_ier_d       = m_ier_q;
        prod_d        = prod_q;
        start         = 1'b0;
        sel           = 1'b0;
        done          = 1'b0;
        busy          = 1'b1;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy         = 1'b0;
                bus.in_ready = rst_n;
                if (bus.in_valid) begin
                    m_cand_d = bus.a_in;
                    m_ier_d  = bus.b_in;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                start   = 1'b1;
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                // Final iteration weights the multiplier sign bit negatively.
                sel   = (cnt_q == LastIter);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d = StCapt;
                end
            end
            StCapt: begin
                // The datapath result is only valid during this one cycle.
                done    = 1'b1;
                prod_d  = mul_result[2*k-1:0];
                state_d = StHold;
            end
            StHold: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.prod = prod_q;
    assign m_cand   = m_cand_q;
    assign m_ier    = m_ier_q;

endmodule

// File: tb/tb_signed_rshift_mul_ctrl.sv
// Scoreboard bench for signed_rshift_mul_ctrl at k=3 and k=8, each wired
// to a behavioural right-shift signed multiplier datapath.
module tb_signed_rshift_mul_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // ---------------- k = 3 ----------------
    signed_rshift_mul_ctrl_if #(.k(3)) bus3 ();
    logic [2:0] m_cand3, m_ier3;
    logic       start3, sel3, done3, busy3;
    logic [6:0] mul_result3;

    signed_rshift_mul_ctrl #(.k(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus3),
        .m_cand     (m_cand3),
        .m_ier      (m_ier3),
        .start      (start3),
        .sel        (sel3),
        .done       (done3),
        .mul_result (mul_result3),
        .busy       (busy3)
    );

    // Datapath model: no reset, loads on start, add/shift on every other clock.
    logic [3:0] acc3 = '0;
    logic [2:0] mq3 = '0;
    logic [3:0] s3;
    assign s3 = acc3 + (mq3[0] ? (sel3 ? -{m_cand3[2], m_cand3} : {m_cand3[2], m_cand3}) : 4'd0);
    always @(posedge clk) begin
        if (start3) begin
            acc3 <= '0;
            mq3  <= m_ier3;
        end else begin
            {acc3, mq3} <= 7'($signed({s3, mq3}) >>> 1);
        end
    end
    assign mul_result3 = done3 ? {acc3, mq3} : 7'h55;

    // ---------------- k = 8 ----------------
    signed_rshift_mul_ctrl_if #(.k(8)) bus8 ();
    logic [7:0]  m_cand8, m_ier8;
    logic        start8, sel8, done8, busy8;
    logic [16:0] mul_result8;

    signed_rshift_mul_ctrl #(.k(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus8),
        .m_cand     (m_cand8),
        .m_ier      (m_ier8),
        .start      (start8),
        .sel        (sel8),
        .done       (done8),
        .mul_result (mul_result8),
        .busy       (busy8)
    );

    logic [8:0] acc8 = '0;
    logic [7:0] mq8 = '0;
    logic [8:0] s8;
    assign s8 = acc8 + (mq8[0] ? (sel8 ? -{m_cand8[7], m_cand8} : {m_cand8[7], m_cand8}) : 9'd0);
    always @(posedge clk) begin
        if (start8) begin
            acc8 <= '0;
            mq8  <= m_ier8;
        end else begin
            {acc8, mq8} <= 17'($signed({s8, mq8}) >>> 1);
        end
    end
    assign mul_result8 = done8 ? {acc8, mq8} : 17'h0AAAA;

    // ---------------- scoreboard helpers ----------------
    logic [5:0]  exp3[$];
    logic [15:0] exp8[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: actual timeout required completion", name);
    endtask

    function automatic logic [5:0] ref3(input logic [2:0] a, input logic [2:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[5:0];
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    // ---------------- k = 3 monitor ----------------
    // since3 = negedges since the acceptance edge (1 = LOAD, 2..4 = RUN, 5 = CAPT, 6 = HOLD).
    int         since3 = 999;
    int         cyc3 = 0;
    int         last_start3 = -1;
    bit         b2b3 = 1'b0;
    logic       prev_v3 = 1'b0;
    logic       prev_take3 = 1'b0;
    logic [5:0] prev_prod3 = '0;

    always @(negedge clk) begin
        cyc3++;
        if (!rst_n) begin
            since3  = 999;
            prev_v3 = 1'b0;
        end else begin
            if (bus3.in_valid && bus3.in_ready) since3 = 0;
            else if (since3 < 999) since3++;

            if (since3 >= 1 && since3 <= 6) begin
                check("start3_timing", 32'(start3), 32'(since3 == 1));
                check("sel3_timing", 32'(sel3), 32'(since3 == 4));
                check("done3_timing", 32'(done3), 32'(since3 == 5));
                check("out_valid3_timing", 32'(bus3.out_valid), 32'(since3 == 6));
            end else if (since3 > 6 && since3 < 999) begin
                check("start3_quiet", 32'(start3), 32'd0);
            end

            if (bus3.out_valid) begin
                check("in_ready3_hold", 32'(bus3.in_ready), 32'd0);
                check("busy3_hold", 32'(busy3), 32'd1);
                if (prev_v3 && !prev_take3) check("prod3_stable", 32'(bus3.prod), 32'(prev_prod3));
                if (exp3.size() == 0) begin
                    check("out_valid3_unexpected", 32'(bus3.out_valid), 32'd0);
                end else if (bus3.out_ready) begin
                    check("prod3", 32'(bus3.prod), 32'(exp3.pop_front()));
                end
            end

            if (start3 && b2b3) begin
                if (last_start3 >= 0) check("start3_gap", 32'(cyc3 - last_start3), 32'd7);
                last_start3 = cyc3;
            end

            prev_v3    = bus3.out_valid;
            prev_take3 = bus3.out_valid && bus3.out_ready;
            prev_prod3 = bus3.prod;
        end
    end

    // ---------------- k = 8 monitor (always back-to-back) ----------------
    int cyc8 = 0;
    int last_start8 = -1;
    int dones8 = 0;

    always @(negedge clk) begin
        cyc8++;
        if (rst_n) begin
            if (done8) dones8++;
            if (start8) begin
                if (last_start8 >= 0) begin
                    check("start8_gap", 32'(cyc8 - last_start8), 32'd12);
                    check("done8_per_op", 32'(dones8), 32'd1);
                end
                last_start8 = cyc8;
                dones8      = 0;
            end
            if (bus8.out_valid) begin
                if (exp8.size() == 0) begin
                    check("out_valid8_unexpected", 32'(bus8.out_valid), 32'd0);
                end else if (bus8.out_ready) begin
                    check("prod8", 32'(bus8.prod), 32'(exp8.pop_front()));
                end
            end
        end
    end

    // ---------------- drivers (all act at posedge + 1) ----------------
    task automatic send3(input logic [2:0] a, input logic [2:0] b, input logic [5:0] e,
                         output int waited);
        waited = 0;
        bus3.in_valid = 1'b1;
        bus3.a_in     = a;
        bus3.b_in     = b;
        while (!bus3.in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!bus3.in_ready) fail_now("send3_accept");
        else exp3.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
        int waited = 0;
        bus8.in_valid = 1'b1;
        bus8.a_in     = a;
        bus8.b_in     = b;
        while (!bus8.in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!bus8.in_ready) fail_now("send8_accept");
        else exp8.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain3();
        int n = 0;
        bus3.in_valid = 1'b0;
        while ((exp3.size() != 0 || busy3) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) fail_now("drain3");
    endtask

    task automatic drain8();
        int n = 0;
        bus8.in_valid = 1'b0;
        while ((exp8.size() != 0 || busy8) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) fail_now("drain8");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int n;
        logic [2:0] ra, rb;
        logic [7:0] a8, b8;

        bus3.in_valid = 1'b0; bus3.a_in = '0; bus3.b_in = '0; bus3.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_in_ready3", 32'(bus3.in_ready), 32'd0);
        check("rst_busy3", 32'(busy3), 32'd0);
        check("rst_out_valid3", 32'(bus3.out_valid), 32'd0);
        check("rst_prod3", 32'(bus3.prod), 32'd0);
        check("rst_strobes3", 32'({start3, sel3, done3}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("idle_in_ready3", 32'(bus3.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed products
        send3(3'b101, 3'b010, 6'h3A, w);
        drain3();
        send3(3'b100, 3'b100, 6'h10, w);
        drain3();
        send3(3'b011, 3'b111, 6'h3D, w);
        drain3();

        // Output stall with in_valid held high
        bus3.out_ready = 1'b0;
        send3(3'b010, 3'b011, 6'h06, w);
        bus3.a_in = 3'b001;
        bus3.b_in = 3'b100;
        n = 0;
        while (!bus3.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus3.out_valid) fail_now("stall_out_valid");
        repeat (10) @(posedge clk);
        #1;
        check("stall_out_valid3", 32'(bus3.out_valid), 32'd1);
        check("stall_prod3", 32'(bus3.prod), 32'h06);
        bus3.out_ready = 1'b1;
        send3(3'b001, 3'b100, 6'h3C, w);
        check("stall_accept_next", 32'(w), 32'd1);
        drain3();

        // Reset in the second RUN cycle
        send3(3'b011, 3'b101, 6'h37, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp3.delete();
        #1;
        check("midrst_in_ready3", 32'(bus3.in_ready), 32'd0);
        check("midrst_busy3", 32'(busy3), 32'd0);
        check("midrst_out_valid3", 32'(bus3.out_valid), 32'd0);
        check("midrst_strobes3", 32'({start3, sel3, done3}), 32'd0);
        check("midrst_operands3", 32'({m_cand3, m_ier3}), 32'd0);
        check("midrst_prod3", 32'(bus3.prod), 32'd0);
        bus3.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("postrst_idle3", 32'({bus3.in_ready, busy3}), 32'b10);
        send3(3'b110, 3'b011, 6'h3A, w);
        drain3();

        // Exhaustive sweep, back-to-back
        b2b3 = 1'b1;
        last_start3 = -1;
        for (int i = 0; i < 64; i++) begin
            ra = 3'(i >> 3);
            rb = 3'(i);
            send3(ra, rb, ref3(ra, rb), w);
        end
        for (int i = 0; i < 6; i++) begin
            ra = 3'($urandom);
            rb = 3'($urandom);
            send3(ra, rb, ref3(ra, rb), w);
        end
        drain3();
        b2b3 = 1'b0;

        // k = 8 back-to-back burst
        send8(8'h80, 8'h80, 16'h4000);
        send8(8'h7F, 8'h80, 16'hC080);
        for (int i = 0; i < 8; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            send8(a8, b8, ref8(a8, b8));
        end
        drain8();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
